// File: rtl/key_cmd_queue.sv
// key_cmd_queue: synchronises eight key levels into press/auto-repeat commands buffered in a DEPTH-entry valid/ready FIFO
module key_cmd_queue #(
  parameter int DEPTH = 4,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_PERIOD = 7_500_000,
  parameter int CNT_W = 25
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       a_left,
  input  logic                       w_up,
  input  logic                       s_down,
  input  logic                       d_right,
  input  logic                       esc_retry,
  input  logic                       enter_next,
  input  logic                       backspace_retract,
  input  logic                       m_switch,
  output logic                       cmd_valid,
  output logic [2:0]                 cmd_code,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] keys, s1, s2, s3, press;
  logic [2:0] press_code, ev_code;
  logic rep_on, rep_hold, rep_fire, ev, flush, pop, full, push;
  logic [1:0] rep_code;
  logic [CNT_W-1:0] rep_cnt;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign keys = {m_switch, backspace_retract, enter_next, esc_retry, d_right, s_down, w_up, a_left};
  assign press = s2 & ~s3;
  always_comb begin
    press_code = '0;
    for (int i = 7; i >= 0; i--) if (press[i]) press_code = 3'(i);
  end
  assign rep_hold = rep_on & s2[rep_code];
  assign rep_fire = rep_hold & (rep_cnt == CNT_W'(1));
  assign ev = (|press) | rep_fire;
  assign ev_code = (|press) ? press_code : {1'b0, rep_code};
  assign flush = (|press) & (press_code == 3'd4 | press_code == 3'd5);
  assign pop = cmd_valid & cmd_ready;
  assign full = queue_count == CW'(DEPTH);
  assign push = ev & ~flush & (~full | pop);
  assign cmd_valid = queue_count != '0;
  assign cmd_code = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      rep_on <= 1'b0;
      rep_code <= '0;
      rep_cnt <= '0;
    end else begin
      s1 <= keys;
      s2 <= s1;
      s3 <= s2;
      if ((|press) & ~press_code[2]) begin
        rep_on <= 1'b1;
        rep_code <= press_code[1:0];
        rep_cnt <= CNT_W'(REPEAT_DELAY);
      end else if (flush | ~rep_hold) begin
        rep_on <= 1'b0;
      end else begin
        rep_cnt <= rep_fire ? CNT_W'(REPEAT_PERIOD) : rep_cnt - CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      queue_count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= ev & ~flush & full & ~pop;
      if (flush) begin
        mem[0] <= ev_code;
        rd_ptr <= '0;
        wr_ptr <= AW'(1);
        queue_count <= CW'(1);
      end else begin
        if (push) begin
          mem[wr_ptr] <= ev_code;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        queue_count <= queue_count + CW'(push) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_key_cmd_queue.sv
// tb_key_cmd_queue: random and directed stimulus against a queue-based command model
module tb_key_cmd_queue;
  localparam int DEPTH = 4, RD = 20, RP = 8;
  logic clk = 0, reset_n = 0, cmd_ready = 0;
  logic [7:0] k = '0;
  logic cmd_valid, overflow;
  logic [2:0] cmd_code, queue_count;
  int cmp = 0, bad = 0, ovf_pulses = 0;
  longint n = 0;
  int q[$];
  bit m_ovf = 0, rec = 0;
  longint obs[$];
  key_cmd_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_left(k[0]), .w_up(k[1]), .s_down(k[2]), .d_right(k[3]),
    .esc_retry(k[4]), .enter_next(k[5]), .backspace_retract(k[6]), .m_switch(k[7]),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
    .queue_count(queue_count), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, n);
    end
  endtask
  task automatic cyc(int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic tap(int key);
    k[key] = 1'b1;
    cyc(4);
    k[key] = 1'b0;
    cyc(4);
  endtask
  task automatic pop_one();
    cmd_ready = 1'b1;
    cyc(1);
    cmd_ready = 1'b0;
  endtask
  // Reference: s2/s3 are the key samples taken two and three edges before the current one.
  initial begin
    logic [7:0] hist [3];
    logic [7:0] pr;
    int pc, code, trk_code;
    bit trk_on, fire, ev, pop;
    longint due;
    hist = '{8'h0, 8'h0, 8'h0};
    trk_on = 0;
    trk_code = 0;
    due = 0;
    forever begin
      @(posedge clk);
      n++;
      if (!reset_n) begin
        q = {};
        m_ovf = 0;
        trk_on = 0;
        hist = '{8'h0, 8'h0, 8'h0};
      end else begin
        pr = hist[1] & ~hist[2];
        pc = 0;
        for (int i = 7; i >= 0; i--) if (pr[i]) pc = i;
        fire = 0;
        if (pr != 0 && pc < 4) begin
          trk_on = 1;
          trk_code = pc;
          due = n + RD;
        end else if (pr != 0 && (pc == 4 || pc == 5)) trk_on = 0;
        else if (trk_on) begin
          if (!hist[1][trk_code]) trk_on = 0;
          else if (n == due) begin
            fire = 1;
            due = n + RP;
          end
        end
        ev = pr != 0 || fire;
        code = pr != 0 ? pc : trk_code;
        pop = q.size() > 0 && cmd_ready;
        m_ovf = 0;
        if (ev && (code == 4 || code == 5)) q = {code};
        else begin
          if (pop) void'(q.pop_front());
          if (ev) begin
            if (q.size() < DEPTH) q.push_back(code);
            else m_ovf = 1;
          end
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = k;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      check("valid", cmd_valid, q.size() > 0);
      check("count", queue_count, q.size());
      check("overflow", overflow, m_ovf);
      if (q.size() > 0) check("code", cmd_code, q[0]);
      if (overflow) ovf_pulses++;
      if (rec && cmd_valid && cmd_code == 0) obs.push_back(n);
    end
  end
  initial begin
    int base, rp;
    cyc(3);
    check("rst_valid", cmd_valid, 0);
    check("rst_code", cmd_code, 0);
    check("rst_count", queue_count, 0);
    check("rst_ovf", overflow, 0);
    reset_n = 1;
    cyc(2);
    k[1] = 1;
    cyc(2);
    check("lat_e2_valid", cmd_valid, 0);
    cyc(1);
    check("lat_e3_valid", cmd_valid, 1);
    check("lat_e3_code", cmd_code, 1);
    check("lat_e3_count", queue_count, 1);
    cyc(7);
    k[1] = 0;
    cyc(4);
    pop_one();
    check("single_pop_count", queue_count, 0);
    check("single_pop_valid", cmd_valid, 0);
    cyc(4);
    base = ovf_pulses;
    repeat (5) tap(3);
    check("ovf_count", queue_count, 4);
    check("ovf_pulses", ovf_pulses - base, 1);
    repeat (4) begin
      check("ovf_drain", cmd_code, 3);
      pop_one();
    end
    repeat (4) tap(0);
    base = ovf_pulses;
    k[3] = 1;
    cyc(2);
    cmd_ready = 1;
    cyc(1);
    cmd_ready = 0;
    check("pp_count", queue_count, 4);
    cyc(3);
    k[3] = 0;
    cyc(4);
    check("pp_no_ovf", ovf_pulses - base, 0);
    foreach (q[i]) ;
    for (int i = 0; i < 4; i++) begin
      check("pp_order", cmd_code, i == 3 ? 3 : 0);
      pop_one();
    end
    tap(0);
    tap(1);
    tap(2);
    check("fl_pre_count", queue_count, 3);
    k[4] = 1;
    cyc(2);
    cmd_ready = 1;
    cyc(1);
    cmd_ready = 0;
    check("fl_count", queue_count, 1);
    check("fl_code", cmd_code, 4);
    cyc(2);
    k[4] = 0;
    cyc(4);
    k[2] = 1;
    k[7] = 1;
    cyc(4);
    k = '0;
    cyc(4);
    check("sim_count", queue_count, 2);
    pop_one();
    check("sim_code", cmd_code, 2);
    pop_one();
    check("sim_empty", queue_count, 0);
    cyc(4);
    obs = {};
    cmd_ready = 1;
    rec = 1;
    k[0] = 1;
    cyc(50);
    k[0] = 0;
    cyc(20);
    rec = 0;
    cmd_ready = 0;
    check("rep_n", obs.size(), 5);
    if (obs.size() == 5) begin
      check("rep_1", 32'(obs[1] - obs[0]), 20);
      check("rep_2", 32'(obs[2] - obs[0]), 28);
      check("rep_3", 32'(obs[3] - obs[0]), 36);
      check("rep_4", 32'(obs[4] - obs[0]), 44);
    end
    tap(0);
    tap(6);
    tap(3);
    check("ar_pre_count", queue_count, 3);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("ar_valid", cmd_valid, 0);
    check("ar_count", queue_count, 0);
    cyc(2);
    reset_n = 1;
    cyc(2);
    for (int c = 0; c < 3200; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(23) == 0) k[b] = ~k[b];
      rp = (c / 300) % 4;
      cmd_ready = rp == 0 ? 1'b0 : $urandom_range(99) < (rp == 1 ? 25 : rp == 2 ? 50 : 90);
      if (c == 1500) begin
        #2 reset_n = 0;
        cyc(2);
        reset_n = 1;
      end
      cyc(1);
    end
    k = '0;
    cmd_ready = 0;
    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Converts the eight PS/2 keyboard command levels (a_left, w_up, s_down, d_right, esc_retry, enter_next, backspace_retract, m_switch) into a stream of discrete 3-bit game commands. It sits directly downstream of the keyboard decoder and upstream of the Sokoban game engine. Each key press becomes exactly one command; held direction keys auto-repeat. Commands are buffered in a small FIFO and drained with a valid/ready handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 25_000_000: cycles a direction key is held before the first repeat (0.5 s at 50 MHz).
- REPEAT_PERIOD, 7_500_000: cycles between subsequent repeats.
- CNT_W, 25: width of the repeat counter; must hold max(REPEAT_DELAY, REPEAT_PERIOD).
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- a_left, w_up, s_down, d_right  in  1 each  direction key levels; high while the key is pressed.
- esc_retry, enter_next, backspace_retract, m_switch  in  1 each  control key levels.
- cmd_valid  out  1  FIFO not empty.
- cmd_code  out  3  FIFO head: 0 left, 1 up, 2 down, 3 right, 4 retry, 5 next, 6 retract, 7 switch.
- cmd_ready  in  1  consumer accepts the head.
- queue_count  out  log2(DEPTH)+1  number of entries held.
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Key inputs may be asynchronous to clk. Each key passes through a 2-flop synchroniser (s1, s2) and a delay flop (s3).
- **Press event:** a key is pressed on any cycle where s2 & ~s3.
- **One event per cycle:** if several keys are pressed in the same cycle, the lowest code wins; the rest are discarded silently (no overflow).
- **Auto-repeat** (direction keys only):
  - The repeat tracker latches the code of the most recent direction press event and loads the counter with REPEAT_DELAY.
  - While that key's s2 stays high, the counter decrements. On reaching 1, it raises a repeat event with the latched code and reloads REPEAT_PERIOD.
  - Releasing the tracked key (s2 low) idles the tracker.
  - A new direction press retargets the tracker.
  - A press event on the same cycle as a repeat event wins; the repeat is dropped.
- **Flush commands** (retry, next): the event clears the FIFO, writes itself as the sole entry (queue_count = 1), and idles the repeat tracker. A simultaneous pop is ignored. overflow is never raised by a flush.
- **Normal event** (codes 0–3, 6, 7):
  - Pushed if the FIFO is not full, or if it is full and a pop occurs on the same cycle (push and pop both take effect; count unchanged).
  - Otherwise the event is dropped and overflow pulses.
- **Pop:** occurs when cmd_valid & cmd_ready. Pointers wrap modulo DEPTH.
- cmd_code is undefined-but-stable (last head value) while cmd_valid is low. The consumer must ignore it.

## Timing
- Reset values: cmd_valid 0, cmd_code 0, queue_count 0, overflow 0, all synchroniser flops 0, repeat tracker idle, pointers 0.
- A key held through reset deassertion produces one press event after reset.
- Reset asserted mid-operation clears the FIFO immediately (asynchronous). Queued commands are lost.
- **Latency:** an input first high before edge E1 is captured in s1 at E1 and in s2 at E2. The event is written at E3, so cmd_valid is high after E3.
- cmd_valid, cmd_code and queue_count are registered or derived only from registers; there is no combinational path from cmd_ready.
- cmd_ready is sampled at the rising edge. The next head appears the cycle after a pop.
- **Repeat:** with a key held continuously, the first repeat is written REPEAT_DELAY cycles after the press write, then every REPEAT_PERIOD cycles.
- overflow is high for exactly the one cycle following the dropped write edge.

## Test plan
- **Single press:** reset, cmd_ready=0, pulse w_up high for 10 cycles. Expect cmd_valid high 3 edges after the rise, cmd_code=1, queue_count=1. Raise cmd_ready for one cycle; expect queue_count=0 and cmd_valid=0.
- **Overflow:** DEPTH=4, cmd_ready=0, five separate d_right presses. Expect queue_count=4, one overflow pulse on the 5th press, and the FIFO holding 3,3,3,3.
- **Full with simultaneous push/pop:** FIFO full, cmd_ready=1 on the cycle the 5th press writes. Expect no overflow, count stays 4, new tail=3.
- **Flush:** queue left,up,down, then press esc_retry. Expect queue_count=1, cmd_code=4, and cmd_ready asserted on the flush cycle has no effect.
- **Auto-repeat:** REPEAT_DELAY=20, REPEAT_PERIOD=8, hold a_left for 50 cycles with cmd_ready=1. Expect pops of code 0 at the press write, then +20, +28, +36, +44 cycles; nothing after release.
- **Simultaneous keys / reset:**
  - s_down and m_switch rise on the same cycle: expect only code 2.
  - Assert reset_n=0 with 3 entries queued: expect cmd_valid and queue_count 0 immediately.
